// File: rtl/datamem_responder.sv
// rtl/datamem_responder.sv - load/store responder with wait states and RISC-V width/sign rules
module datamem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // Storage is deliberately not reset; contents survive a reset pulse.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          out_of_range;

  logic [31:0]   resp_rdata_d;
  logic          resp_err_d;
  logic [3:0]    wr_mask_d;
  logic [31:0]   wr_data_d;

  assign word_idx     = addr_q[AW+1:2];
  assign lane         = addr_q[1:0];
  assign rd_word      = mem_q[word_idx];
  assign rd_shift     = rd_word >> {lane, 3'b000};
  assign byte_sel     = rd_shift[7:0];
  assign half_sel     = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign out_of_range = (addr_q[31:2] >= 30'(DEPTH_WORDS));

  // Decode of the captured request; only consumed while in S_RESP.
  always_comb begin
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    wr_mask_d    = 4'b0000;
    wr_data_d    = 32'h0;
    case (f3_q)
      F3_B: begin
        resp_rdata_d = {{24{byte_sel[7]}}, byte_sel};
        wr_mask_d    = 4'b0001 << lane;
        wr_data_d    = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        resp_err_d   = lane[0];
        resp_rdata_d = {{16{half_sel[15]}}, half_sel};
        wr_mask_d    = 4'b0011 << lane;
        wr_data_d    = {2{wdata_q[15:0]}};
      end
      F3_W: begin
        resp_err_d   = (lane != 2'b00);
        resp_rdata_d = rd_word;
        wr_mask_d    = 4'b1111;
        wr_data_d    = wdata_q;
      end
      F3_BU: begin
        resp_err_d   = we_q;
        resp_rdata_d = {24'h0, byte_sel};
      end
      F3_HU: begin
        resp_err_d   = we_q | lane[0];
        resp_rdata_d = {16'h0, half_sel};
      end
      default: begin
        resp_err_d = 1'b1;
      end
    endcase
    if (out_of_range) begin
      resp_err_d = 1'b1;
    end
    if (resp_err_d || !we_q) begin
      wr_mask_d = 4'b0000;
    end
    if (resp_err_d || we_q) begin
      resp_rdata_d = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask_d[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_data_d[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      f3_q         <= 3'b000;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            f3_q        <= req_funct3;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              cnt_q   <= WAIT_LOAD;
              state_q <= S_WAIT;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= resp_rdata_d;
          resp_err_q   <= resp_err_d;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
